// File: rtl/led_fade_scheduler.sv
// LED fade scheduler: ramps intensity to zero, swaps color, then ramps up to the target level.
// Optional macro LED_FADE_QUEUE_EN adds a one-deep pending request buffer.
module led_fade_scheduler #(
  parameter int unsigned STEP_DIV_W = 16
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  start,
  input  logic [5:0]            color_in,
  input  logic [7:0]            level_in,
  input  logic [STEP_DIV_W-1:0] step_div,
  output logic [5:0]            color_out,
  output logic [7:0]            intensity,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned COLOR_W = 6;
  localparam int unsigned LEVEL_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    LOAD     = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [STEP_DIV_W-1:0] cnt_q, cnt_d;
  logic [COLOR_W-1:0]    tgt_color_q, tgt_color_d;
  logic [LEVEL_W-1:0]    tgt_level_q, tgt_level_d;
  logic [COLOR_W-1:0]    color_d;
  logic [LEVEL_W-1:0]    intensity_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  tick_c;

`ifdef LED_FADE_QUEUE_EN
  logic                  pend_valid_q, pend_valid_d;
  logic [COLOR_W-1:0]    pend_color_q, pend_color_d;
  logic [LEVEL_W-1:0]    pend_level_q, pend_level_d;
`endif

  // Step strobe; >= keeps a freshly lowered step_div from stalling the ramp.
  assign tick_c = (state_q != IDLE) && (cnt_q >= step_div);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    tgt_color_d = tgt_color_q;
    tgt_level_d = tgt_level_q;
    color_d     = color_out;
    intensity_d = intensity;
    done_d      = 1'b0;
`ifdef LED_FADE_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_color_d = pend_color_q;
    pend_level_d = pend_level_q;
`endif

    if (state_q == IDLE || tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = STEP_DIV_W'(cnt_q + 1'b1);
    end

    case (state_q)
      IDLE: begin
`ifdef LED_FADE_QUEUE_EN
        if (pend_valid_q) begin
          tgt_color_d  = pend_color_q;
          tgt_level_d  = pend_level_q;
          pend_valid_d = 1'b0;
          state_d      = FADE_OUT;
        end else if (start && !done_q_int()) begin
          tgt_color_d = color_in;
          tgt_level_d = level_in;
          state_d     = FADE_OUT;
        end
        // A start in the done cycle (or behind a launching request) is queued.
        if (start && (done || pend_valid_q)) begin
          pend_valid_d = 1'b1;
          pend_color_d = color_in;
          pend_level_d = level_in;
        end
`else
        if (start) begin
          tgt_color_d = color_in;
          tgt_level_d = level_in;
          state_d     = FADE_OUT;
        end
`endif
      end
      FADE_OUT: begin
        if (tick_c) begin
          if (intensity != '0) begin
            intensity_d = LEVEL_W'(intensity - 1'b1);
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        color_d = tgt_color_q;
        cnt_d   = '0;
        state_d = FADE_IN;
      end
      FADE_IN: begin
        if (tick_c) begin
          if (intensity < tgt_level_q) begin
            intensity_d = LEVEL_W'(intensity + 1'b1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LED_FADE_QUEUE_EN
    if (state_q != IDLE && start) begin
      pend_valid_d = 1'b1;
      pend_color_d = color_in;
      pend_level_d = level_in;
    end
`endif

    busy_d = (state_d != IDLE);
  end

`ifdef LED_FADE_QUEUE_EN
  function automatic logic done_q_int();
    return done;
  endfunction
`endif

  // State and output registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_color_q <= '0;
      tgt_level_q <= '0;
      color_out   <= '0;
      intensity   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_color_q <= tgt_color_d;
      tgt_level_q <= tgt_level_d;
      color_out   <= color_d;
      intensity   <= intensity_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef LED_FADE_QUEUE_EN
  // One-deep pending request; a later start overwrites earlier data.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pend_valid_q <= 1'b0;
      pend_color_q <= '0;
      pend_level_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_color_q <= pend_color_d;
      pend_level_q <= pend_level_d;
    end
  end
`endif

endmodule

// File: tb/tb_led_fade_scheduler.sv
// Scoreboard bench for led_fade_scheduler: per-cycle expected traces are queued at stimulus time.
module tb_led_fade_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  color_in;
  logic [7:0]  level_in;
  logic [15:0] step_div;
  logic [5:0]  color_out;
  logic [7:0]  intensity;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] inten;
    logic [5:0] color;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned vectors;
  int unsigned miscompares;
  logic [5:0]  cur_color;
  int          cur_level;

  led_fade_scheduler #(.STEP_DIV_W(16)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .start     (start),
    .color_in  (color_in),
    .level_in  (level_in),
    .step_div  (step_div),
    .color_out (color_out),
    .intensity (intensity),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic b, input logic d, input int v, input logic [5:0] c);
    obs_t e;
    e.busy  = b;
    e.done  = d;
    e.inten = 8'(v);
    e.color = c;
    exp_q.push_back(e);
  endtask

  // Expected trace of one fade: down to 0, one LOAD cycle, up to level, then the done cycle.
  task automatic push_fade(input logic [5:0] c, input int level, input int sd);
    int p;
    p = sd + 1;
    for (int v = cur_level; v >= 0; v--) repeat (p) push(1'b1, 1'b0, v, cur_color);
    push(1'b1, 1'b0, 0, cur_color);
    for (int v = 0; v <= level; v++) repeat (p) push(1'b1, 1'b0, v, c);
    push(1'b0, 1'b1, level, c);
    cur_color = c;
    cur_level = level;
  endtask

  task automatic launch(input logic [5:0] c, input int level);
    color_in = c;
    level_in = 8'(level);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Pops and compares one expected sample per cycle, optionally pulsing start mid-fade.
  task automatic drain(input string tag, input int inj_at, input logic [5:0] ic, input int il);
    obs_t e;
    int   idx;
    idx = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk({tag, "_busy"},  32'(busy),      32'(e.busy));
      chk({tag, "_done"},  32'(done),      32'(e.done));
      chk({tag, "_inten"}, 32'(intensity), 32'(e.inten));
      chk({tag, "_color"}, 32'(color_out), 32'(e.color));
      if (idx == inj_at) begin
        color_in = ic;
        level_in = 8'(il);
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      idx++;
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_tail_busy"}, 32'(busy), 32'(exp_q.size() != 0));
    chk({tag, "_tail_done"}, 32'(done), 32'd0);
  endtask

  task automatic fade(input string tag, input logic [5:0] c, input int level, input int sd,
                      input int inj_at, input logic [5:0] ic, input int il);
    step_div = 16'(sd);
    push_fade(c, level, sd);
`ifdef LED_FADE_QUEUE_EN
    if (inj_at >= 0) push_fade(ic, il, sd);
`endif
    launch(c, level);
    drain(tag, inj_at, ic, il);
  endtask

  initial begin
    int found;
    vectors     = 0;
    miscompares = 0;
    cur_color   = 6'd0;
    cur_level   = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    color_in    = 6'd0;
    level_in    = 8'd0;
    step_div    = 16'd0;

    repeat (3) @(negedge clk);
    chk("rst_inten", 32'(intensity), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    rst_n = 1'b1;

    fade("basic",   6'b100001, 2, 0, -1, 6'd0, 0);
    fade("up3",     6'b011110, 3, 0, -1, 6'd0, 0);
    fade("from3",   6'b100001, 2, 0, -1, 6'd0, 0);
    fade("same",    6'b100001, 2, 0, -1, 6'd0, 0);
    fade("div4",    6'b100001, 2, 4, -1, 6'd0, 0);

    // Lower the step period mid-ramp and expect the next step within two cycles.
    step_div = 16'd4;
    launch(6'b010010, 3);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (intensity == 8'd1 && color_out == 6'b010010) found = 1;
    end
    chk("lower_reach1", 32'(found), 32'd1);
    step_div = 16'd1;
    @(negedge clk);
    chk("lower_hold", 32'(intensity), 32'd1);
    @(negedge clk);
    chk("lower_step", 32'(intensity), 32'd2);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk("lower_done", 32'(found), 32'd1);
    chk("lower_level", 32'(intensity), 32'd3);
    @(negedge clk);
    cur_color = 6'b010010;
    cur_level = 3;

    fade("max255",  6'b001100, 255, 0, -1, 6'd0, 0);
    fade("busystart", 6'b110011, 5, 0, 3, 6'b000111, 9);

    // Reset asserted mid fade-in.
    step_div = 16'd0;
    launch(6'b101010, 120);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (intensity == 8'd100 && color_out == 6'b101010) found = 1;
    end
    chk("midrst_reach", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_inten", 32'(intensity), 32'd0);
    chk("midrst_color", 32'(color_out), 32'd0);
    chk("midrst_busy",  32'(busy),      32'd0);
    chk("midrst_done",  32'(done),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_busy", 32'(busy), 32'd0);
      chk("postrst_done", 32'(done), 32'd0);
    end
    cur_color = 6'd0;
    cur_level = 0;

    fade("afterrst", 6'b010101, 4, 0, -1, 6'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
